tour_cmd_seq: RTL and testbench

Sequences the computed Knight's Tour into `cmd_proc` commands and arbitrates `cmd_proc`'s command input between the UART command path and the tour. After `start_tour`, it walks the tour move list one index at a time. Each L-shaped knight move becomes two single-axis commands: a vertical move, then a horizontal move. Outside a tour, UART commands pass straight through to `cmd_proc`.

---
 rtl/knight_pkg.sv | 25 ++
 rtl/tour_move_dec.sv | 37 +++
 rtl/tour_cmd_seq.sv | 108 ++++++++++
 tb/tb_tour_cmd_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/knight_pkg.sv
// rtl/knight_pkg.sv - shared knight tour command constants and state type
package knight_pkg;

  localparam logic [3:0] MOVE    = 4'b0010;
  localparam logic [3:0] MOVE_FF = 4'b0011;

  localparam logic [7:0] HDG_NORTH = 8'h00;
  localparam logic [7:0] HDG_WEST  = 8'h3F;
  localparam logic [7:0] HDG_SOUTH = 8'h7F;
  localparam logic [7:0] HDG_EAST  = 8'hBF;

  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam logic [7:0] ACK     = 8'h5A;

  localparam int NUM_MOVES_DEF = 24;

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    WAIT_V,
    HORZ,
    WAIT_H
  } tour_state_t;

endpackage

// File: rtl/tour_move_dec.sv
// rtl/tour_move_dec.sv - splits a one-hot knight move into vertical and horizontal half-moves
module tour_move_dec
  import knight_pkg::*;
(
  input  logic [7:0] move,
  output logic [7:0] v_hdg,
  output logic [3:0] v_sq,
  output logic [7:0] h_hdg,
  output logic [3:0] h_sq
);

  // Lowest set bit has priority; no bits set decodes as a null move north.
  always_comb begin
    v_hdg = HDG_NORTH;
    v_sq  = 4'd0;
    h_hdg = HDG_NORTH;
    h_sq  = 4'd0;
    if (move[0]) begin
      v_hdg = HDG_NORTH; v_sq = 4'd2; h_hdg = HDG_EAST; h_sq = 4'd1;
    end else if (move[1]) begin
      v_hdg = HDG_NORTH; v_sq = 4'd2; h_hdg = HDG_WEST; h_sq = 4'd1;
    end else if (move[2]) begin
      v_hdg = HDG_NORTH; v_sq = 4'd1; h_hdg = HDG_WEST; h_sq = 4'd2;
    end else if (move[3]) begin
      v_hdg = HDG_SOUTH; v_sq = 4'd1; h_hdg = HDG_WEST; h_sq = 4'd2;
    end else if (move[4]) begin
      v_hdg = HDG_SOUTH; v_sq = 4'd2; h_hdg = HDG_WEST; h_sq = 4'd1;
    end else if (move[5]) begin
      v_hdg = HDG_SOUTH; v_sq = 4'd2; h_hdg = HDG_EAST; h_sq = 4'd1;
    end else if (move[6]) begin
      v_hdg = HDG_SOUTH; v_sq = 4'd1; h_hdg = HDG_EAST; h_sq = 4'd2;
    end else if (move[7]) begin
      v_hdg = HDG_NORTH; v_sq = 4'd1; h_hdg = HDG_EAST; h_sq = 4'd2;
    end
  end

endmodule

// File: rtl/tour_cmd_seq.sv
// rtl/tour_cmd_seq.sv - knight tour command sequencer and UART/tour command arbiter
// TOUR_FANFARE_EN: horizontal half-moves use the MOVE_FF opcode.
module tour_cmd_seq
  import knight_pkg::*;
#(
  parameter int NUM_MOVES = NUM_MOVES_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [15:0]                  cmd_UART,
  input  logic                         cmd_rdy_UART,
  input  logic                         start_tour,
  input  logic [7:0]                   move,
  output logic [$clog2(NUM_MOVES)-1:0] mv_indx,
  input  logic                         clr_cmd_rdy,
  input  logic                         send_resp,
  output logic [15:0]                  cmd,
  output logic                         cmd_rdy,
  output logic [7:0]                   resp
);

  localparam int IW = $clog2(NUM_MOVES);

`ifdef TOUR_FANFARE_EN
  localparam logic [3:0] H_OP = MOVE_FF;
`else
  localparam logic [3:0] H_OP = MOVE;
`endif

  tour_state_t   state, nxt_state;
  logic [IW-1:0] nxt_indx;
  logic [7:0]    v_hdg, h_hdg;
  logic [3:0]    v_sq, h_sq;
  logic [15:0]   v_cmd, h_cmd;
  logic          last_move;

  tour_move_dec u_dec (
    .move  (move),
    .v_hdg (v_hdg),
    .v_sq  (v_sq),
    .h_hdg (h_hdg),
    .h_sq  (h_sq)
  );

  assign v_cmd     = {MOVE, v_hdg, v_sq};
  assign h_cmd     = {H_OP, h_hdg, h_sq};
  assign last_move = (mv_indx == IW'(NUM_MOVES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mv_indx <= '0;
    end else begin
      state   <= nxt_state;
      mv_indx <= nxt_indx;
    end
  end

  // Each half-move: present with cmd_rdy until consumed, then hold until completed.
  always_comb begin
    nxt_state = state;
    nxt_indx  = mv_indx;
    cmd       = cmd_UART;
    cmd_rdy   = cmd_rdy_UART;
    resp      = POS_ACK;
    case (state)
      IDLE: begin
        if (start_tour) begin
          nxt_indx  = '0;
          nxt_state = VERT;
        end
      end
      VERT: begin
        cmd     = v_cmd;
        cmd_rdy = 1'b1;
        resp    = ACK;
        if (clr_cmd_rdy) nxt_state = WAIT_V;
      end
      WAIT_V: begin
        cmd     = v_cmd;
        cmd_rdy = 1'b0;
        resp    = ACK;
        if (send_resp) nxt_state = HORZ;
      end
      HORZ: begin
        cmd     = h_cmd;
        cmd_rdy = 1'b1;
        resp    = ACK;
        if (clr_cmd_rdy) nxt_state = WAIT_H;
      end
      WAIT_H: begin
        cmd     = h_cmd;
        cmd_rdy = 1'b0;
        resp    = last_move ? POS_ACK : ACK;
        if (send_resp) begin
          if (last_move) begin
            nxt_state = IDLE;
          end else begin
            nxt_indx  = mv_indx + 1'b1;
            nxt_state = VERT;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// tb/tb_tour_cmd_seq.sv - self-checking bench for tour_cmd_seq against a handshake-count model
module tb_tour_cmd_seq;

  localparam int N = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [7:0]  resp;

  logic [7:0] tmem [0:31];
  int DX [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int DY [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

`ifdef TOUR_FANFARE_EN
  localparam logic [3:0] HOP = 4'h3;
`else
  localparam logic [3:0] HOP = 4'h2;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int hs_cnt = 0;

  bit m_in_tour = 0;
  bit m_waiting = 0;
  int m_hs = 0;

  tour_cmd_seq #(.NUM_MOVES(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .start_tour   (start_tour),
    .move         (move),
    .mv_indx      (mv_indx),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .resp         (resp)
  );

  always #5 clk = ~clk;
  assign move = tmem[mv_indx];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, expv);
    end
  endtask

  function automatic logic [15:0] half_cmd(input logic [7:0] mv, input bit horiz);
    int dx, dy, d, sq;
    logic [7:0] h;
    logic [3:0] op;
    dx = 0;
    dy = 0;
    for (int b = 7; b >= 0; b--) if (mv[b]) begin dx = DX[b]; dy = DY[b]; end
    d  = horiz ? dx : dy;
    sq = (d < 0) ? -d : d;
    if (horiz) h = (d > 0) ? 8'hBF : (d < 0) ? 8'h3F : 8'h00;
    else       h = (d < 0) ? 8'h7F : 8'h00;
    op = horiz ? HOP : 4'h2;
    return {op, h, sq[3:0]};
  endfunction

  // Model: a tour is 2*N handshakes; each is "issued" until consumed, then "waiting" until completed.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_in_tour = 0; m_waiting = 0; m_hs = 0;
    end else if (!m_in_tour) begin
      if (start_tour) begin m_in_tour = 1; m_waiting = 0; m_hs = 0; end
    end else if (!m_waiting) begin
      if (clr_cmd_rdy) m_waiting = 1;
    end else if (send_resp) begin
      m_waiting = 0;
      m_hs++;
      if (m_hs == 2 * N) m_in_tour = 0;
    end
  end

  always @(negedge clk) begin
    int idx;
    bit hz;
    idx = (m_hs / 2 > N - 1) ? N - 1 : m_hs / 2;
    hz  = (m_hs % 2) == 1;
    chk("mv_indx", mv_indx, idx);
    if (!m_in_tour) begin
      chk("cmd_idle", cmd, cmd_UART);
      chk("cmd_rdy_idle", cmd_rdy, cmd_rdy_UART);
      chk("resp_idle", resp, 8'hA5);
    end else begin
      chk("cmd_tour", cmd, half_cmd(tmem[idx], hz));
      chk("cmd_rdy_tour", cmd_rdy, !m_waiting);
      chk("resp_tour", resp, (m_waiting && hz && idx == N - 1) ? 8'hA5 : 8'h5A);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_rdy();
    int c = 0;
    while (!cmd_rdy && c < 20) begin step(); c++; end
    chk("wait_cmd_rdy", cmd_rdy, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) tmem[i] = 8'h01 << (i % 8);
    tmem[0]  = 8'h01; tmem[1]  = 8'h08; tmem[8]  = 8'h00;
    tmem[9]  = 8'h0C; tmem[10] = 8'hA0;

    rst = 1'b1; cmd_UART = 16'h0; cmd_rdy_UART = 1'b0; start_tour = 1'b0;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    step(); step();
    chk("rst_resp", resp, 8'hA5);
    chk("rst_mv_indx", mv_indx, 5'd0);
    chk("rst_cmd_rdy", cmd_rdy, 1'b0);
    rst = 1'b0;
    step();

    cmd_UART = 16'h2002; cmd_rdy_UART = 1'b1;
    #1;
    chk("pass_cmd", cmd, 16'h2002);
    chk("pass_rdy_hi", cmd_rdy, 1'b1);
    chk("pass_resp", resp, 8'hA5);
    step();
    cmd_rdy_UART = 1'b0;
    #1;
    chk("pass_rdy_lo", cmd_rdy, 1'b0);

    start_tour = 1'b1;
    step();
    start_tour = 1'b0;
    chk("first_cmd_rdy", cmd_rdy, 1'b1);
    chk("first_cmd", cmd, 16'h2002);

    for (int i = 0; i < N; i++) begin
      for (int h = 0; h < 2; h++) begin
        wait_rdy();
        if (i == 0 && h == 1) begin
          chk("m0_h_cmd", cmd, {HOP, 12'hBF1});
          chk("m0_h_resp", resp, 8'h5A);
        end
        if (i == 1 && h == 0) chk("m1_v_cmd", cmd, 16'h27F1);
        if (i == 1 && h == 1) chk("m1_h_cmd", cmd, {HOP, 12'h3F2});
        if (i == 8 && h == 0) chk("m8_v_cmd", cmd, 16'h2000);
        if (i == 9 && h == 0) chk("m9_v_cmd", cmd, 16'h2001);
        if (i == 2 && h == 0) begin
          send_resp = 1'b1; step(); send_resp = 1'b0;
          chk("early_resp_cmd_rdy", cmd_rdy, 1'b1);
        end
        if (i == 4 && h == 0) begin start_tour = 1'b1; step(); start_tour = 1'b0; end
        clr_cmd_rdy = 1'b1;
        if (i == 3 && h == 0) send_resp = 1'b1;
        step();
        clr_cmd_rdy = 1'b0; send_resp = 1'b0;
        hs_cnt++;
        if (i == 0 && h == 0) begin
          cmd_UART = 16'h1111; cmd_rdy_UART = 1'b1;
          step();
          chk("uart_blocked", cmd_rdy, 1'b0);
          cmd_rdy_UART = 1'b0;
        end
        if (i == 5 && h == 1) begin clr_cmd_rdy = 1'b1; step(); clr_cmd_rdy = 1'b0; end
        if (i == N - 1 && h == 1) chk("final_resp", resp, 8'hA5);
        send_resp = 1'b1;
        step();
        send_resp = 1'b0;
      end
    end
    chk("handshakes", hs_cnt, 48);
    chk("end_mv_indx", mv_indx, 5'd23);
    chk("end_resp", resp, 8'hA5);
    cmd_rdy_UART = 1'b1;
    #1;
    chk("end_passthru", cmd_rdy, 1'b1);
    step();
    cmd_rdy_UART = 1'b0;

    start_tour = 1'b1;
    step();
    start_tour = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int h = 0; h < 2; h++) begin
        wait_rdy();
        if (i == 7 && h == 1) break;
        clr_cmd_rdy = 1'b1; step(); clr_cmd_rdy = 1'b0;
        send_resp = 1'b1; step(); send_resp = 1'b0;
      end
    end
    chk("pre_rst_mv_indx", mv_indx, 5'd7);
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("abort_mv_indx", mv_indx, 5'd0);
    chk("abort_cmd_rdy", cmd_rdy, 1'b1);
    chk("abort_cmd", cmd, 16'h1234);
    step(); step();
    rst = 1'b0;
    step(); step(); step();
    cmd_rdy_UART = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
